// File: rtl/dual_input_debouncer_pkg.sv
// rtl/dual_input_debouncer_pkg.sv - shared FSM state encoding and default parameters
`timescale 1ns/100ps
package dual_input_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    WAIT1   = 2'd1,
    STABLE1 = 2'd2,
    WAIT0   = 2'd3
  } deb_state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 8;
  localparam int DEF_CNT_W         = 4;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one input: synchroniser, stability counter, FSM, edge pulses
`timescale 1ns/100ps
module debounce_channel
  import dual_input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk_tb,
  input  logic rst_tb,
  input  logic en,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sy;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_d, rise_d, fall_d;

  // The synchroniser keeps running while en is low so sy is never stale on re-enable.
  always_ff @(posedge clk_tb or negedge rst_tb) begin
    if (!rst_tb) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign sy = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_tb or negedge rst_tb) begin
    if (!rst_tb) begin
      state_q <= STABLE0;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      case (state_q)
        STABLE0: if (sy) begin
          state_d = WAIT1;
          cnt_d   = CNT_ONE;
        end
        WAIT1: begin
          if (!sy) begin
            state_d = STABLE0;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE1;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE1: if (!sy) begin
          state_d = WAIT0;
          cnt_d   = CNT_ONE;
        end
        WAIT0: begin
          if (sy) begin
            state_d = STABLE1;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE0;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE0;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dual_input_debouncer.sv
// rtl/dual_input_debouncer.sv - two independent debounce channels sharing clock, reset, enable
`timescale 1ns/100ps
module dual_input_debouncer
  import dual_input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk_tb,
  input  logic rst_tb,
  input  logic en,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_out,
  output logic b_out,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  // Elaboration-time legality checks; nothing is generated when parameters are sane.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("dual_input_debouncer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("dual_input_debouncer: STABLE_CYCLES must be >= 2");
  end
  if ((2 ** CNT_W) - 1 < STABLE_CYCLES) begin : g_bad_cnt
    $error("dual_input_debouncer: CNT_W too narrow for STABLE_CYCLES");
  end

  debounce_channel #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_a (
    .clk_tb (clk_tb),
    .rst_tb (rst_tb),
    .en     (en),
    .raw    (a_raw),
    .level  (a_out),
    .rise   (a_rise),
    .fall   (a_fall)
  );

  debounce_channel #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_b (
    .clk_tb (clk_tb),
    .rst_tb (rst_tb),
    .en     (en),
    .raw    (b_raw),
    .level  (b_out),
    .rise   (b_rise),
    .fall   (b_fall)
  );

endmodule

// File: tb/tb_dual_input_debouncer.sv
// tb/tb_dual_input_debouncer.sv - randomized and directed bench against a behavioural debounce model
`timescale 1ns/100ps
module tb_dual_input_debouncer;
  import dual_input_debouncer_pkg::*;

  localparam int S  = DEF_SYNC_STAGES;
  localparam int SC = DEF_STABLE_CYCLES;

  logic clk_tb = 1'b0;
  logic rst_tb, en, a_raw, b_raw;
  logic a_out, b_out, a_rise, a_fall, b_rise, b_fall;

  dual_input_debouncer dut (
    .clk_tb (clk_tb),
    .rst_tb (rst_tb),
    .en     (en),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a_out  (a_out),
    .b_out  (b_out),
    .a_rise (a_rise),
    .a_fall (a_fall),
    .b_rise (b_rise),
    .b_fall (b_fall)
  );

  always #1 clk_tb = ~clk_tb;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a level flips once it has disagreed with the synced input
  // for SC consecutive enabled cycles; any agreeing enabled cycle clears the run.
  bit ha[$], hb[$];
  bit m_a_out, m_b_out, m_a_rise, m_a_fall, m_b_rise, m_b_fall;
  int m_a_run, m_b_run;
  logic p_a_rise, p_a_fall, p_b_rise, p_b_fall;

  task automatic check_eq(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ha = {};
    hb = {};
    for (int i = 0; i < S; i++) begin
      ha.push_back(1'b0);
      hb.push_back(1'b0);
    end
    m_a_out = 0; m_b_out = 0; m_a_run = 0; m_b_run = 0;
    m_a_rise = 0; m_a_fall = 0; m_b_rise = 0; m_b_fall = 0;
  endtask

  task automatic model_ch(input bit sy, input bit e, inout bit o, inout int r,
                          output bit ri, output bit fa);
    ri = 0;
    fa = 0;
    if (e) begin
      if (sy != o) begin
        r++;
        if (r == SC) begin
          o = ~o;
          r = 0;
          if (o) ri = 1;
          else   fa = 1;
        end
      end else begin
        r = 0;
      end
    end
  endtask

  task automatic check_all();
    check_eq("a_out",  int'(a_out),  int'(m_a_out));
    check_eq("b_out",  int'(b_out),  int'(m_b_out));
    check_eq("a_rise", int'(a_rise), int'(m_a_rise));
    check_eq("a_fall", int'(a_fall), int'(m_a_fall));
    check_eq("b_rise", int'(b_rise), int'(m_b_rise));
    check_eq("b_fall", int'(b_fall), int'(m_b_fall));
    check_eq("a_excl", int'(a_rise & a_fall), 0);
    check_eq("b_excl", int'(b_rise & b_fall), 0);
    check_eq("a_rise_width", int'(a_rise & p_a_rise), 0);
    check_eq("a_fall_width", int'(a_fall & p_a_fall), 0);
    check_eq("b_rise_width", int'(b_rise & p_b_rise), 0);
    check_eq("b_fall_width", int'(b_fall & p_b_fall), 0);
    p_a_rise = a_rise; p_a_fall = a_fall; p_b_rise = b_rise; p_b_fall = b_fall;
  endtask

  // One clock: model updates on the rising edge, DUT is checked on the falling edge.
  task automatic step();
    bit sya, syb;
    @(posedge clk_tb);
    if (!rst_tb) begin
      model_reset();
    end else begin
      sya = ha[0];
      syb = hb[0];
      ha.push_back(a_raw); void'(ha.pop_front());
      hb.push_back(b_raw); void'(hb.pop_front());
      model_ch(sya, en, m_a_out, m_a_run, m_a_rise, m_a_fall);
      model_ch(syb, en, m_b_out, m_b_run, m_b_rise, m_b_fall);
    end
    @(negedge clk_tb);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk_tb);
    a_raw = 0; b_raw = 0; en = 1;
    #0.3 rst_tb = 0;
    model_reset();
    repeat (3) step();
    rst_tb = 1;
  endtask

  // Runs max edges; en is low for edges off_s .. off_s+off_n-1; reports first pulse edges.
  task automatic run_count(input int max, input int off_s, input int off_n,
                           output int hit_a, output int hit_b, output int hit_af);
    hit_a = 0; hit_b = 0; hit_af = 0;
    for (int i = 1; i <= max; i++) begin
      en = !(i >= off_s && i < off_s + off_n);
      step();
      if (!en) check_eq("en0_no_pulse", int'(a_rise | a_fall | b_rise | b_fall), 0);
      if (a_rise && hit_a == 0)  hit_a  = i;
      if (b_rise && hit_b == 0)  hit_b  = i;
      if (a_fall && hit_af == 0) hit_af = i;
    end
    en = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ha_e, hb_e, haf_e, ha2, hb2, haf2;
    p_a_rise = 0; p_a_fall = 0; p_b_rise = 0; p_b_fall = 0;
    rst_tb = 0; en = 1; a_raw = 0; b_raw = 0;
    model_reset();
    do_reset();
    check_eq("reset_a_out", int'(a_out), 0);

    // clean held edge on A only: rise on edge 10, B untouched
    a_raw = 1;
    run_count(14, 0, 0, ha_e, hb_e, haf_e);
    check_eq("t2_a_edge", ha_e, S + SC);
    check_eq("t2_b_none", hb_e, 0);

    // glitch of 5 cycles is rejected
    do_reset();
    a_raw = 1;
    run_count(5, 0, 0, ha_e, hb_e, haf_e);
    a_raw = 0;
    run_count(20, 0, 0, ha2, hb2, haf2);
    check_eq("t3_no_rise", ha_e + ha2, 0);
    check_eq("t3_no_fall", haf_e + haf2, 0);

    // simultaneous edges on both channels
    do_reset();
    a_raw = 1; b_raw = 1;
    run_count(14, 0, 0, ha_e, hb_e, haf_e);
    check_eq("t4_a_edge", ha_e, S + SC);
    check_eq("t4_b_edge", hb_e, S + SC);

    // en low for 3 cycles mid-WAIT1 delays acceptance by 3
    do_reset();
    a_raw = 1;
    run_count(16, 6, 3, ha_e, hb_e, haf_e);
    check_eq("t5_a_edge", ha_e, S + SC + 3);

    // reset mid-WAIT1 discards the partial count
    do_reset();
    a_raw = 1;
    run_count(8, 0, 0, ha_e, hb_e, haf_e);
    check_eq("t6_pre_none", ha_e, 0);
    #0.3 rst_tb = 0;
    model_reset();
    #0.2 check_eq("t6_async_out", int'(a_out), 0);
    repeat (2) step();
    rst_tb = 1;
    run_count(14, 0, 0, ha_e, hb_e, haf_e);
    check_eq("t6_a_edge", ha_e, S + SC);

    // asynchronous reset with both levels high clears everything at once
    b_raw = 1;
    repeat (12) step();
    check_eq("t1_pre_a", int'(a_out), 1);
    check_eq("t1_pre_b", int'(b_out), 1);
    #0.3 rst_tb = 0;
    model_reset();
    #0.2;
    check_eq("t1_async_all", int'({a_out, b_out, a_rise, a_fall, b_rise, b_fall}), 0);
    @(negedge clk_tb);
    repeat (3) step();
    rst_tb = 1;

    // randomized traffic with sparse toggles and occasional enable drop
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) a_raw = ~a_raw;
      if ($urandom_range(0, 13) == 0) b_raw = ~b_raw;
      en = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
